// File: rtl/enc_sched_pkg.sv
// Shared types and defaults for the encoder transmit scheduler.
// Contents: frame-sequencer state enum, state encoding width, and the
// default NUM_REQ / DATA_W / GAP_CYCLES values used by enc_tx_scheduler.
package enc_sched_pkg;

  localparam int unsigned STATE_W        = 2;
  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned GAP_CYCLES_DEF = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the lowest-index valid requester at or after rrPtr_i (with wrap).
// Ports:
//   reqValid_i  per-requester request vector
//   rrPtr_i     index searched first
//   anyReq_o    at least one request pending
//   winner_o    index of the selected requester (0 when none)
module rr_arbiter
  import enc_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid_i,
  input  logic [IDX_W-1:0]   rrPtr_i,
  output logic               anyReq_o,
  output logic [IDX_W-1:0]   winner_o
);

  // One spare bit so rrPtr + offset can exceed NUM_REQ-1 before wrapping.
  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] idx;

  always_comb begin
    anyReq_o = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rrPtr_i} + (IDX_W+1)'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!anyReq_o && reqValid_i[idx[IDX_W-1:0]]) begin
        anyReq_o = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/enc_tx_scheduler.sv
// Round-robin scheduler sharing one parallel-to-serial encoder between
// NUM_REQ byte requesters. Each frame: LOAD (1 clk), SHIFT (DATA_W clks,
// encParallel held), GAP (GAP_CYCLES clks), then re-arbitration.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   reqValid     per-requester byte pending, held until acked
//   reqData      requester i byte at [i*DATA_W +: DATA_W]
//   reqAck       one-hot, one-cycle accept pulse
//   encParallel  byte presented to the encoder
//   encLoad      one-cycle encoder capture pulse
//   busy         high in LOAD, SHIFT, GAP
//   grantId      current / last granted requester
//   txCount      16-bit frame counter (only with TX_FRAME_COUNT_EN defined)
module enc_tx_scheduler
  import enc_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter  int unsigned DATA_W     = DATA_W_DEF,
  parameter  int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqAck,
  output logic [DATA_W-1:0]         encParallel,
  output logic                      encLoad,
  output logic                      busy,
  output logic [IDX_W-1:0]          grantId
`ifdef TX_FRAME_COUNT_EN
  ,
  output logic [15:0]               txCount
`endif
);

  localparam int unsigned     BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    rrPtr_q, rrPtr_d;
  logic [BIT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
  logic [DATA_W-1:0]   encParallel_q, encParallel_d;
  logic                encLoad_q, encLoad_d;
  logic [NUM_REQ-1:0]  reqAck_q, reqAck_d;
  logic [IDX_W-1:0]    grantId_q, grantId_d;

  logic                anyReq;
  logic [IDX_W-1:0]    winner;
  logic                arb;
  logic [DATA_W-1:0]   reqByte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqByte[g] = reqData[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .reqValid_i (reqValid),
    .rrPtr_i    (rrPtr_q),
    .anyReq_o   (anyReq),
    .winner_o   (winner)
  );

  always_comb begin
    state_d       = state_q;
    rrPtr_d       = rrPtr_q;
    bitCnt_d      = bitCnt_q;
    gapCnt_d      = gapCnt_q;
    encParallel_d = encParallel_q;
    encLoad_d     = 1'b0;
    reqAck_d      = '0;
    grantId_d     = grantId_q;
    arb           = 1'b0;

    unique case (state_q)
      IDLE:  arb = 1'b1;
      LOAD: begin
        state_d  = SHIFT;
        bitCnt_d = BIT_W'(DATA_W - 1);
      end
      SHIFT: begin
        if (bitCnt_q == '0) begin
          if (GAP_CYCLES != 0) begin
            state_d  = GAP;
            gapCnt_d = GAP_W'(GAP_CYCLES - 1);
          end else begin
            arb = 1'b1;
          end
        end else begin
          bitCnt_d = bitCnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gapCnt_q == '0) arb = 1'b1;
        else                gapCnt_d = gapCnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // LOAD-state outputs are registered on the edge entering LOAD, so they
    // are visible for exactly the one LOAD cycle.
    if (arb) begin
      if (anyReq) begin
        state_d       = LOAD;
        encParallel_d = reqByte[winner];
        encLoad_d     = 1'b1;
        reqAck_d      = NUM_REQ'(1) << winner;
        grantId_d     = winner;
        rrPtr_d       = (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      rrPtr_q       <= '0;
      bitCnt_q      <= '0;
      gapCnt_q      <= '0;
      encParallel_q <= '0;
      encLoad_q     <= 1'b0;
      reqAck_q      <= '0;
      grantId_q     <= '0;
    end else begin
      state_q       <= state_d;
      rrPtr_q       <= rrPtr_d;
      bitCnt_q      <= bitCnt_d;
      gapCnt_q      <= gapCnt_d;
      encParallel_q <= encParallel_d;
      encLoad_q     <= encLoad_d;
      reqAck_q      <= reqAck_d;
      grantId_q     <= grantId_d;
    end
  end

  assign encParallel = encParallel_q;
  assign encLoad     = encLoad_q;
  assign reqAck      = reqAck_q;
  assign grantId     = grantId_q;
  assign busy        = (state_q != IDLE);

`ifdef TX_FRAME_COUNT_EN
  logic [15:0] txCount_q;

  always_ff @(posedge clock) begin
    if (!reset)         txCount_q <= '0;
    else if (encLoad_q) txCount_q <= txCount_q + 16'd1;
  end

  assign txCount = txCount_q;
`endif

endmodule

// File: doc/enc_tx_scheduler.md
Name: enc_tx_scheduler

Overview:
- Shares one parallel-to-serial encoder between NUM_REQ byte requesters using round-robin arbitration.
- Sequences each frame: grants a requester, loads its byte onto the encoder's parallel input, holds it stable for the full serialisation window, then enforces an inter-frame gap.
- Sits directly upstream of the encoder; its encParallel output drives the encoder parallel input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, encoder parallel width; also the serialisation length in clocks.
- GAP_CYCLES, 2, idle clocks between frames (0 allowed = back-to-back).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- reqValid  in  NUM_REQ  per-requester "byte pending"; held until acked.
- reqData  in  NUM_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W].
- reqAck  out  NUM_REQ  one-hot, one-cycle pulse when the byte is accepted.
- encParallel  out  DATA_W  byte presented to the encoder.
- encLoad  out  1  one-cycle pulse: encoder captures encParallel this cycle.
- busy  out  1  high in LOAD, SHIFT and GAP.
- grantId  out  clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (reset==0 at an edge) drives:
  - state=IDLE, rrPtr=0, bitCnt=0, gapCnt=0.
  - reqAck=0, encParallel=0, encLoad=0, busy=0, grantId=0.
- Reset asserted mid-frame aborts the frame immediately. No ack is reissued.
- States and transitions:
  - IDLE: if any reqValid, pick the winner by round-robin starting at rrPtr, then go to LOAD next cycle. Otherwise stay.
  - LOAD (1 cycle):
    - Registered outputs: encParallel=reqData[winner], encLoad=1, reqAck[winner]=1, grantId=winner.
    - rrPtr=(winner+1) mod NUM_REQ; bitCnt=DATA_W-1.
    - Go to SHIFT.
  - SHIFT: encParallel held constant; bitCnt decrements each clock. At bitCnt==0:
    - GAP_CYCLES>0: go to GAP with gapCnt=GAP_CYCLES-1.
    - GAP_CYCLES==0: re-arbitrate in that same cycle and go to LOAD if any request is pending, else IDLE.
  - GAP: gapCnt decrements. At 0, re-arbitrate exactly as IDLE does (go to LOAD or IDLE).
- Latency:
  - reqValid seen in IDLE at edge t gives encLoad/reqAck at t+1.
  - One frame occupies 1+DATA_W+GAP_CYCLES clocks.
- Handshake:
  - Requester samples reqAck high, then may drop or change reqValid/reqData from the next cycle.
  - reqData is captured only in LOAD.
  - reqValid deasserted before grant means the request is withdrawn, with no error.
- Arbitration fairness:
  - A continuously requesting index waits at most NUM_REQ-1 frames.
  - rrPtr advances only on a grant.
- Simultaneous requests: the lowest index at or after rrPtr (with wrap) wins. rrPtr wraps NUM_REQ-1 to 0.
- busy=1 in LOAD, SHIFT and GAP; 0 in IDLE.
- encLoad is never high in two consecutive cycles.

Optional Feature:
- Macro: TX_FRAME_COUNT_EN.
- Defined: adds output txCount (16 bits).
  - Reset to 0.
  - Increments on each encLoad pulse.
  - Wraps 0xFFFF to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package enc_sched_pkg:
  - state enum {IDLE, LOAD, SHIFT, GAP}.
  - Encoding-width localparam.
  - Default constants for DATA_W and GAP_CYCLES.
- Sub-module rr_arbiter (combinational):
  - Inputs: reqValid, rrPtr.
  - Outputs: anyReq, winner index.
  - Instantiated once.

Test Plan:
- Reset: hold reset=0 for 3 clocks with reqValid=4'b1111 -> all outputs 0, no encLoad; first encLoad 2 clocks after reset release, grantId=0.
- Single request: reqValid[2]=1, reqData byte2=8'hA8 -> next clock encLoad=1, reqAck=4'b0100, encParallel=8'hA8 held 8 clocks, then busy=0 after 2 gap clocks.
- All four requesting continuously:
  - Grant order is 0,1,2,3,0.
  - encLoad pulses are spaced 11 clocks apart (1+8+2).
- Back-to-back with GAP_CYCLES=0, requesters 1 and 3:
  - encLoad pulses are 9 clocks apart.
  - No IDLE cycle in between.
- Withdrawal and abort:
  - Drop reqValid[1] before grant -> never acked.
  - Assert reset in SHIFT -> outputs return to 0 next clock.
- TX_FRAME_COUNT_EN: run 5 frames -> txCount=5; preload near wrap -> 0xFFFF rolls to 0.
